// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int INST_W     = 32;
    localparam int ROM_ADDR_W = 10;
    localparam logic [INST_W-1:0] RESET_PC = '0;

    // One buffered fetch result: byte PC plus the instruction word read there.
    typedef struct packed {
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry in-order FIFO of fetch results. The head is a register, so the
// consumer sees it one cycle after the push. Flush clears the occupancy, but
// a pop issued in the same cycle still counts as a completed transfer.
module fetch_buf2
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t ent0, ent1;

    assign head = ent0;

    // Entry storage and occupancy; ent0 is always the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= din;
                    else               ent1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // count is 1 or 2 here; occupancy is unchanged
                    if (count == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end else begin
                        ent0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    // The issue rule upstream must never let a third entry arrive.
    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && count == 2'd2));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one ROM word read per
// cycle while there is room, and parks returned words in a 2-entry buffer
// that decode drains over valid/ready. Redirect flushes buffered and
// in-flight fetches; halt stops new issues but lets in-flight data land.
// N must stay equal to INST_W-1 so PCs fit the buffered entry type.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter int         N        = INST_W - 1,
    parameter int         ADDR_W   = ROM_ADDR_W,
    parameter logic [N:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [N:0]        mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N:0]        out_inst,
    output logic [N:0]        out_pc,
    input  logic              redirect_valid,
    input  logic [N:0]        redirect_pc,
    input  logic              halt
);

    localparam logic [N:0] PC_STEP  = (N+1)'(4);
    localparam logic [N:0] ALN_MASK = ~((N+1)'(3));

    logic [N:0]   fetch_pc;
    logic [N:0]   tag_pc;
    logic [N:0]   tgt_pc;
    logic [N:0]   issue_pc;
    logic         inflight;
    logic         cancel;
    logic         pop;
    logic         push;
    logic [1:0]   count;
    logic [2:0]   occ;
    fetch_entry_t din;
    fetch_entry_t head;

    assign tgt_pc   = redirect_pc & ALN_MASK;
    assign issue_pc = redirect_valid ? tgt_pc : fetch_pc;
    assign pop      = out_valid && out_ready;

    // Slots already spoken for after this cycle's pop: buffered plus the
    // word arriving now. A redirect empties both, so the target always fits.
    assign occ      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign mem_en   = !rst && !halt && (redirect_valid || occ < 3'd2);
    assign mem_addr = issue_pc[ADDR_W+1:2];

    // Word returning this cycle was fetched down the old path.
    assign cancel   = inflight && redirect_valid;
    assign push     = inflight && !cancel;
    assign din.pc   = tag_pc;
    assign din.inst = mem_rdata;

    // PC, in-flight flag and the tag that pairs the returning word with its PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            tag_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= mem_en;
            if (mem_en) begin
                tag_pc   <= issue_pc;
                fetch_pc <= issue_pc + PC_STEP;
            end else if (redirect_valid) begin
                fetch_pc <= tgt_pc;
            end
        end
    end

    fetch_buf2 u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .head  (head),
        .count (count)
    );

    assign out_valid = (count != 2'd0);
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. Stimulus pushes the expected delivery
// stream into a queue; independent monitors pop and compare on every
// accepted transfer. A second instance with RESET_PC=0xFFC covers wrap.
module tb_if_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst, mem_en, out_valid, out_ready, redirect_valid, halt;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = '0;
    logic [31:0] out_inst, out_pc, redirect_pc;

    // wrap instance
    logic        rst_w, mem_en_w, out_valid_w, out_ready_w, redirect_valid_w, halt_w;
    logic [9:0]  mem_addr_w;
    logic [31:0] mem_rdata_w = '0;
    logic [31:0] out_inst_w, out_pc_w, redirect_pc_w;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t qw[$];

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt)
    );

    if_fetch_unit #(.RESET_PC(32'hFFC)) dut_w (
        .clk(clk), .rst(rst_w), .mem_en(mem_en_w), .mem_addr(mem_addr_w),
        .mem_rdata(mem_rdata_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .out_inst(out_inst_w), .out_pc(out_pc_w), .redirect_valid(redirect_valid_w),
        .redirect_pc(redirect_pc_w), .halt(halt_w)
    );

    // ROM contents: word i holds 0x1000 + i
    function automatic logic [31:0] rom(input logic [9:0] a);
        return 32'h1000 + {22'd0, a};
    endfunction

    always @(posedge clk) if (mem_en)   mem_rdata   <= rom(mem_addr);
    always @(posedge clk) if (mem_en_w) mem_rdata_w <= rom(mem_addr_w);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void exp_push(input bit w, input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = rom(pc[11:2]);
        if (w) qw.push_back(e);
        else   q.push_back(e);
    endfunction

    // monitor: main instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: got pc %h, expected none", out_pc);
            end else begin
                e = q.pop_front();
                chk("deliver_pc", out_pc, e.pc);
                chk("deliver_inst", out_inst, e.inst);
            end
        end
    end

    // monitor: wrap instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst_w && out_valid_w && out_ready_w) begin
            if (qw.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery_w: got pc %h, expected none", out_pc_w);
            end else begin
                e = qw.pop_front();
                chk("wrap_pc", out_pc_w, e.pc);
                chk("wrap_inst", out_inst_w, e.inst);
            end
        end
    end

    initial begin
        rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        rst_w = 1'b1; out_ready_w = 1'b1; redirect_valid_w = 1'b0; redirect_pc_w = '0; halt_w = 1'b0;

        @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_pc", out_pc, 32'd0);
        chk("reset_out_inst", out_inst, 32'd0);
        chk("reset_mem_en", {31'd0, mem_en}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rst_w = 1'b0;

        // cycle c starts 1 time unit after a posedge; point checks at negedge
        for (int c = 0; c < 32; c++) begin
            out_ready      = !(c inside {[6:8], 12, 24, 25, 31});
            redirect_valid = (c == 12);
            redirect_pc    = (c == 12) ? 32'h42 : 32'h0;
            halt           = (c inside {[16:19], 31});
            rst            = (c == 25);
            out_ready_w    = (c < 4);

            case (c)
                0: begin
                    for (int i = 0; i < 7; i++) exp_push(1'b0, 32'(i * 4));
                    exp_push(1'b1, 32'hFFC);
                    exp_push(1'b1, 32'h1000);
                end
                12: for (int i = 0; i < 4; i++) exp_push(1'b0, 32'h40 + 32'(i * 4));
                20: begin exp_push(1'b0, 32'h50); exp_push(1'b0, 32'h54); end
                26: for (int i = 0; i < 3; i++) exp_push(1'b0, 32'(i * 4));
                default: ;
            endcase

            @(negedge clk);
            case (c)
                0: begin
                    chk("c0_mem_en", {31'd0, mem_en}, 32'd1);
                    chk("c0_mem_addr", {22'd0, mem_addr}, 32'd0);
                    chk("c0_out_valid", {31'd0, out_valid}, 32'd0);
                    chk("wrap_addr_hi", {22'd0, mem_addr_w}, 32'd1023);
                end
                1: begin
                    chk("c1_mem_addr", {22'd0, mem_addr}, 32'd1);
                    chk("c1_out_valid", {31'd0, out_valid}, 32'd0);
                    chk("wrap_addr_lo", {22'd0, mem_addr_w}, 32'd0);
                end
                2: begin
                    chk("c2_mem_addr", {22'd0, mem_addr}, 32'd2);
                    chk("c2_out_valid", {31'd0, out_valid}, 32'd1);
                end
                6, 7: begin
                    chk("bp_mem_en", {31'd0, mem_en}, 32'd0);
                    chk("bp_head_pc", out_pc, 32'h10);
                end
                8: begin
                    chk("bp_head_pc", out_pc, 32'h10);
                    chk("bp_head_inst", out_inst, 32'h1004);
                    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                end
                9: begin
                    chk("bp_resume_en", {31'd0, mem_en}, 32'd1);
                    chk("bp_resume_addr", {22'd0, mem_addr}, 32'd6);
                end
                12: begin
                    chk("redir_mem_en", {31'd0, mem_en}, 32'd1);
                    chk("redir_mem_addr", {22'd0, mem_addr}, 32'd16);
                end
                13: chk("redir_flushed", {31'd0, out_valid}, 32'd0);
                16: chk("halt_mem_en", {31'd0, mem_en}, 32'd0);
                17: begin
                    chk("halt_mem_en", {31'd0, mem_en}, 32'd0);
                    chk("halt_drain_pc", out_pc, 32'h4C);
                end
                18, 19: begin
                    chk("halt_idle_valid", {31'd0, out_valid}, 32'd0);
                    chk("halt_idle_en", {31'd0, mem_en}, 32'd0);
                end
                20: begin
                    chk("unhalt_mem_en", {31'd0, mem_en}, 32'd1);
                    chk("unhalt_mem_addr", {22'd0, mem_addr}, 32'd20);
                end
                21: chk("unhalt_valid", {31'd0, out_valid}, 32'd0);
                25: chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
                26: begin
                    chk("postrst_valid", {31'd0, out_valid}, 32'd0);
                    chk("postrst_pc", out_pc, 32'd0);
                    chk("postrst_inst", out_inst, 32'd0);
                    chk("postrst_mem_en", {31'd0, mem_en}, 32'd1);
                    chk("postrst_addr", {22'd0, mem_addr}, 32'd0);
                end
                27: chk("postrst_valid2", {31'd0, out_valid}, 32'd0);
                default: ;
            endcase
            @(posedge clk);
            #1;
        end

        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("queue_w_drained", 32'(qw.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
